// File: rtl/chorus_pkg.sv
// Shared constants and state encoding for the chorus LFO and the delay buffer.
package chorus_pkg;

  localparam int ADDR_WIDTH  = 14;
  localparam int PHASE_WIDTH = 24;
  localparam int DEPTH_MAX   = 881;
  localparam int BIP_WIDTH   = 17;
  localparam int PROD_WIDTH  = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADVANCE = 3'd1,
    SHAPE   = 3'd2,
    SCALE   = 3'd3,
    DONE    = 3'd4
  } lfo_state_t;

endpackage

// File: rtl/lfo_tri_shaper.sv
// Folds the upper phase bits into a bipolar triangle centred on zero.
module lfo_tri_shaper
  import chorus_pkg::*;
#(
  parameter int PW = PHASE_WIDTH
) (
  input  logic [PW-1:0]                phase_i,
  output logic signed [BIP_WIDTH-1:0]  bip_o
);

  logic [15:0] u;
  logic [15:0] tri_val;

  always_comb begin
    // The 16 bits just below the MSB form the ramp; the MSB picks rising or falling half.
    u       = 16'(phase_i >> (PW - 17));
    tri_val = phase_i[PW-1] ? (16'hFFFF - u) : u;
    bip_o   = $signed({1'b0, tri_val}) - 17'sd32768;
  end

endmodule

// File: rtl/chorus_lfo.sv
// Triangle LFO: per-sample phase advance, shape, scale by depth, registered offset + pulse.
module chorus_lfo
  import chorus_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sampleTick_s_i,
  input  logic                          enable_i,
  input  logic [PHASE_WIDTH-1:0]        rateInc_i,
  input  logic [ADDR_WIDTH-1:0]         depth_i,
  output logic signed [ADDR_WIDTH-1:0]  extraDelay_s_o,
  output logic                          LFOChanged_s_o,
  output logic                          busy_s_o,
  output logic                          overrun_s_o
);

  localparam logic [ADDR_WIDTH-1:0] DEPTH_CLAMP = ADDR_WIDTH'(DEPTH_MAX);

  lfo_state_t                    state_q, state_d;
  logic [PHASE_WIDTH-1:0]        phase_q, phase_d;
  logic [PHASE_WIDTH-1:0]        inc_q, inc_d;
  logic                          en_q, en_d;
  logic [ADDR_WIDTH-1:0]         depth_q, depth_d;
  logic signed [BIP_WIDTH-1:0]   bip_q, bip_d;
  logic signed [PROD_WIDTH-1:0]  prod_q, prod_d;
  logic signed [ADDR_WIDTH-1:0]  extra_q, extra_d;
  logic                          changed_q, changed_d;
  logic                          overrun_q, overrun_d;

  logic signed [BIP_WIDTH-1:0]   bip_shaped;
  logic signed [PROD_WIDTH-1:0]  bip_ext;
  logic signed [PROD_WIDTH-1:0]  depth_ext;
  logic                          accept;

  lfo_tri_shaper #(.PW(PHASE_WIDTH)) u_shaper (
    .phase_i (phase_q),
    .bip_o   (bip_shaped)
  );

  assign bip_ext   = PROD_WIDTH'(bip_q);
  assign depth_ext = PROD_WIDTH'({1'b0, depth_q});

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    phase_d   = phase_q;
    inc_d     = inc_q;
    en_d      = en_q;
    depth_d   = depth_q;
    bip_d     = bip_q;
    prod_d    = prod_q;
    extra_d   = extra_q;
    changed_d = 1'b0;
    overrun_d = overrun_q;
    accept    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sampleTick_s_i) begin
          accept  = 1'b1;
          state_d = ADVANCE;
        end
      end
      ADVANCE: begin
        if (en_q) phase_d = phase_q + inc_q;
        if (sampleTick_s_i) overrun_d = 1'b1;
        state_d = SHAPE;
      end
      SHAPE: begin
        bip_d = bip_shaped;
        if (sampleTick_s_i) overrun_d = 1'b1;
        state_d = SCALE;
      end
      SCALE: begin
        prod_d = bip_ext * depth_ext;
        if (sampleTick_s_i) overrun_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        // en_q still holds the enable of the transaction being finished, even if a new tick is captured now.
        extra_d   = en_q ? ADDR_WIDTH'(prod_q >>> 15) : '0;
        changed_d = 1'b1;
        if (sampleTick_s_i) begin
          accept  = 1'b1;
          state_d = ADVANCE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        overrun_d = 1'b1;
      end
    endcase

    if (accept) begin
      inc_d   = rateInc_i;
      en_d    = enable_i;
      depth_d = (depth_i > DEPTH_CLAMP) ? DEPTH_CLAMP : depth_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      inc_q     <= '0;
      en_q      <= 1'b0;
      depth_q   <= '0;
      bip_q     <= '0;
      prod_q    <= '0;
      extra_q   <= '0;
      changed_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      inc_q     <= inc_d;
      en_q      <= en_d;
      depth_q   <= depth_d;
      bip_q     <= bip_d;
      prod_q    <= prod_d;
      extra_q   <= extra_d;
      changed_q <= changed_d;
      overrun_q <= overrun_d;
    end
  end

  assign extraDelay_s_o = extra_q;
  assign LFOChanged_s_o = changed_q;
  assign busy_s_o       = (state_q != IDLE);
  assign overrun_s_o    = overrun_q;

endmodule

// File: tb/tb_chorus_lfo.sv
// Scoreboard bench for chorus_lfo: directed scenarios plus randomized ticks against a phase/triangle model.
module tb_chorus_lfo;
  import chorus_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic                         tick;
  logic                         enable;
  logic [PHASE_WIDTH-1:0]       rate;
  logic [ADDR_WIDTH-1:0]        depth;
  logic signed [ADDR_WIDTH-1:0] extra;
  logic                         changed;
  logic                         busy;
  logic                         overrun;

  int     checks   = 0;
  int     failures = 0;
  longint exp_q[$];
  longint pulse_cyc[$];
  longint cyc      = 0;
  longint m_phase  = 0;
  int     bcnt;
  int     pk;
  int     n0;
  int     gap;

  chorus_lfo dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sampleTick_s_i (tick),
    .enable_i       (enable),
    .rateInc_i      (rate),
    .depth_i        (depth),
    .extraDelay_s_o (extra),
    .LFOChanged_s_o (changed),
    .busy_s_o       (busy),
    .overrun_s_o    (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Offset from the triangle definition: fold the phase, centre it, scale by depth, round toward -inf.
  function automatic longint model_offset(input longint ph, input longint d, input bit en);
    longint u, t, p, q;
    if (!en) return 0;
    u = (ph >> (PHASE_WIDTH - 17)) % 65536;
    t = (ph >= (longint'(1) << (PHASE_WIDTH - 1))) ? (65535 - u) : u;
    p = (t - 32768) * d;
    q = p / 32768;
    if (p < 0 && (p % 32768) != 0) q = q - 1;
    return q;
  endfunction

  // Caller is just after a posedge; the tick is sampled at the next edge.
  task automatic issue_tick(input longint inc, input bit en, input longint dep);
    longint dc;
    rate   = PHASE_WIDTH'(inc);
    enable = en;
    depth  = ADDR_WIDTH'(dep);
    tick   = 1'b1;
    dc = dep % (longint'(1) << ADDR_WIDTH);
    if (dc > DEPTH_MAX) dc = DEPTH_MAX;
    if (en) m_phase = (m_phase + (inc % (longint'(1) << PHASE_WIDTH))) % (longint'(1) << PHASE_WIDTH);
    exp_q.push_back(model_offset(m_phase, dc, en));
    @(posedge clk);
    #1 tick = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_pending", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && changed === 1'b1) begin
      pulse_cyc.push_back(cyc);
      if (exp_q.size() == 0) check("spurious_pulse", exp_q.size(), 1);
      else check("offset", extra, exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    tick   = 1'b1;
    enable = 1'b1;
    rate   = 24'h123456;
    depth  = 14'd441;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_extra",   extra,   0);
    check("rst_changed", changed, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy",    busy,    0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick = 1'b0;

    bcnt = 0;
    repeat (20) @(negedge clk) bcnt += int'(busy);
    check("idle_busy",   bcnt, 0);
    check("idle_pulses", pulse_cyc.size(), 0);
    idle(1);

    // Zero rate: latency and busy window
    issue_tick(0, 1'b1, 441);
    bcnt = 0;
    pk   = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bcnt += int'(busy);
      if (changed === 1'b1 && pk == 0) pk = k;
    end
    check("latency",     pk,   5);
    check("busy_cycles", bcnt, 4);
    idle(1);

    // Quarter-period rate, ticks every 100 cycles
    for (int i = 0; i < 8; i++) begin
      issue_tick(longint'(1) << 22, 1'b1, 441);
      idle(99);
    end
    wait_drain();

    // Depth clamp, then disable, then re-enable
    for (int i = 0; i < 4; i++) begin issue_tick(longint'(1) << 23, 1'b1, 2000); idle(30); end
    for (int i = 0; i < 3; i++) begin issue_tick(longint'(1) << 23, 1'b0, 2000); idle(30); end
    for (int i = 0; i < 3; i++) begin issue_tick(longint'(1) << 23, 1'b1, 2000); idle(30); end
    wait_drain();

    // Tick coincident with DONE is accepted
    n0 = pulse_cyc.size();
    issue_tick(12345, 1'b1, 300);
    idle(3);
    issue_tick(777777, 1'b1, 500);
    wait_drain();
    idle(5);
    check("coincident_pulses",  pulse_cyc.size() - n0, 2);
    check("coincident_gap",     pulse_cyc[pulse_cyc.size()-1] - pulse_cyc[pulse_cyc.size()-2], 4);
    check("coincident_overrun", overrun, 0);

    // Tick during SHAPE is dropped
    n0 = pulse_cyc.size();
    issue_tick(longint'(1) << 20, 1'b1, 600);
    idle(1);
    pulse_tick();
    wait_drain();
    idle(10);
    check("overrun_set",    overrun, 1);
    check("overrun_pulses", pulse_cyc.size() - n0, 1);
    issue_tick(longint'(1) << 20, 1'b1, 600);
    wait_drain();
    idle(5);
    check("overrun_sticky", overrun, 1);

    // Reset asserted while in SCALE
    issue_tick(longint'(1) << 22, 1'b1, 441);
    @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    m_phase = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_extra",   extra,   0);
    check("midrst_changed", changed, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_busy",    busy,    0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    n0 = pulse_cyc.size();
    idle(10);
    check("midrst_no_pulse", pulse_cyc.size() - n0, 0);
    issue_tick(longint'(1) << 23, 1'b1, 441);
    wait_drain();

    // Randomized ticks with inputs scrambled between ticks
    for (int i = 0; i < 40; i++) begin
      issue_tick(longint'($urandom) % (longint'(1) << PHASE_WIDTH),
                 ($urandom_range(0, 9) != 0),
                 longint'($urandom_range(0, 2047)));
      gap = $urandom_range(3, 40);
      repeat (gap) begin
        @(posedge clk);
        #1;
        rate   = PHASE_WIDTH'($urandom);
        depth  = ADDR_WIDTH'($urandom);
        enable = 1'($urandom);
      end
    end
    wait_drain();
    idle(5);
    check("random_overrun", overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chorus_lfo.md
Name: chorus_lfo

Overview:
- Triangle-wave low-frequency oscillator that generates the signed per-sample delay offset for the chorus delay line.
- Advances a phase accumulator once per audio sample strobe, shapes the phase into a bipolar triangle, and scales it by a depth in samples.
- Presents the result as a registered offset with a one-cycle "new value" pulse.
- Sits directly upstream of the delay buffer: drives its extraDelay and LFOChanged inputs, and shares its sample strobe.

Parameters:
- PHASE_WIDTH, 24, phase accumulator width; one LFO period = 2^PHASE_WIDTH / rateInc_i samples.
- ADDR_WIDTH, 14, width of the offset output; matches the delay buffer address width.
- DEPTH_MAX, 881, upper clamp on depth in samples. Keeps AVG_DELAY + offset >= 0 for AVG_DELAY = 882.

Ports:
- clk, in, 1, system clock (CLK_DSP).
- rst_n, in, 1, synchronous active-low reset.
- sampleTick_s_i, in, 1, one-cycle strobe per audio sample (same net as the delay buffer pktChanged).
- enable_i, in, 1, 1 = modulate; 0 = hold phase and output zero offset.
- rateInc_i, in, PHASE_WIDTH, unsigned phase increment per sample.
- depth_i, in, ADDR_WIDTH, unsigned modulation depth in samples.
- extraDelay_s_o, out, ADDR_WIDTH signed, registered delay offset.
- LFOChanged_s_o, out, 1, registered one-cycle pulse: extraDelay_s_o just updated.
- busy_s_o, out, 1, high while state != IDLE.
- overrun_s_o, out, 1, sticky: a tick arrived while busy.

Behaviour:
- Interface: reset rst_n, synchronous, active-low; clock clk.
- Reset values: phase 0, extraDelay_s_o 0, LFOChanged_s_o 0, overrun_s_o 0, state IDLE.
- Reset wins over every simultaneous event, including a mid-computation reset; no partial result is emitted.
- States:
  - IDLE: on tick, capture rateInc_i, enable_i and min(depth_i, DEPTH_MAX); go to ADVANCE.
  - ADVANCE: if the captured enable is 1, phase <= phase + inc, modulo 2^PHASE_WIDTH, wrap silent; otherwise phase holds. Go to SHAPE.
  - SHAPE: let u = phase[PW-2:PW-17].
    - tri = phase[PW-1] ? 16'hFFFF - u : u.
    - Register bip = signed 17-bit ({1'b0,tri} - 32768), range -32768..32767.
    - Go to SCALE.
  - SCALE: register prod = bip * signed {1'b0, depth}, 32-bit signed. Go to DONE.
  - DONE: extraDelay_s_o <= enable ? ADDR_WIDTH'(prod >>> 15) : 0, where >>> is an arithmetic shift (floor). LFOChanged_s_o <= 1 for exactly one cycle. Next state is ADVANCE if a tick is present, otherwise IDLE.
- Output range is -depth..+depth-1; no saturation is needed because depth <= DEPTH_MAX < 2^(ADDR_WIDTH-1).
- Latency: a tick sampled at edge E0 gives updated outputs and LFOChanged_s_o = 1 in the cycle after edge E4. The pulse never coincides with the tick, so the delay buffer's LFOValid clear-then-set ordering holds.
- A tick in ADVANCE, SHAPE or SCALE is dropped and sets overrun_s_o. Only reset clears overrun_s_o.
- Input changes between ticks have no effect until the next captured tick.
- enable = 0: a pulse is still produced with offset 0, so the downstream buffer never stalls.
- Illegal state encoding goes to IDLE and sets overrun_s_o.

Decomposition:
- Package chorus_pkg holds:
  - ADDR_WIDTH = 14, PHASE_WIDTH = 24, DEPTH_MAX = 881.
  - lfo_state_t enum {IDLE, ADVANCE, SHAPE, SCALE, DONE}, 3-bit.
- The delay buffer imports the same ADDR_WIDTH constant.
- One combinational sub-module, lfo_tri_shaper (phase in, 17-bit signed bip out), is instantiated in the SHAPE stage.

Test Plan:
- Reset behaviour: reset asserted with tick and enable high -> all outputs 0, no pulse; deassert, no tick for 20 cycles -> no pulse, busy 0.
- Zero rate: rateInc = 0, depth = 441, enable = 1, one tick -> LFOChanged pulses 4 edges after the tick edge, offset = -441, busy high for exactly 4 cycles.
- Quarter-period rate: rateInc = 2^22, depth = 441, ticks every 100 cycles -> offsets 0, 440, -1, -441, then the sequence repeats (phase wraps at the 4th tick).
- Depth clamp and disable: depth_i = 2000 with rateInc = 2^23 -> offsets 880, -881 alternate. Then enable = 0 -> offset 0 every tick, pulse still present, phase frozen. Re-enable -> sequence resumes from the frozen phase.
- Overrun: second tick 2 cycles after the first -> overrun_s_o = 1, only one pulse, phase advanced once. A tick coincident with DONE is accepted: a second pulse follows 4 cycles later and overrun stays 0.
- Mid-operation reset: reset asserted in SCALE -> no pulse, outputs 0, next tick yields the phase = rateInc result.
